bsg_cache_dma_to_wormhole_initiator: RTL and testbench

Initiator end of the cache wormhole memory protocol. It takes bsg_cache DMA packets and outbound evict data from one vcache and serializes them into wormhole request packets: header, address, optional mask, then data flits. It receives fill response packets (header plus data flits) and returns the fill data to the cache. It sits between a vcache DMA port and a wormhole router link; its far end is the wormhole test memory or a memory controller.

---
 rtl/bsg_cache_dma_to_wormhole_initiator_pkg.sv | 23 ++
 rtl/bsg_cache_dma_to_wormhole_initiator_counter.sv | 25 ++
 rtl/bsg_cache_dma_to_wormhole_initiator.sv | 204 ++++++++++++++++++++
 tb/tb_bsg_cache_dma_to_wormhole_initiator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_dma_to_wormhole_initiator_pkg.sv
// Opcode type and opcode selection shared by the cache DMA to wormhole initiator.
package bsg_cache_dma_to_wormhole_initiator_pkg;

  typedef enum logic [1:0] {
    e_cache_wh_read             = 2'd0,
    e_cache_wh_write_non_masked = 2'd1,
    e_cache_wh_write_masked     = 2'd2
  } bsg_cache_wh_opcode_e;

  localparam int wh_opcode_width_gp = 2;

  // A full-mask write skips the mask flit on the wire.
  function automatic bsg_cache_wh_opcode_e wh_opcode_sel(input logic write_not_read,
                                                         input logic mask_full);
    if (!write_not_read)
      return e_cache_wh_read;
    else if (mask_full)
      return e_cache_wh_write_non_masked;
    else
      return e_cache_wh_write_masked;
  endfunction

endpackage

// File: rtl/bsg_cache_dma_to_wormhole_initiator_counter.sv
// Small clear/up/down counter used for flit counts and outstanding reads.
module bsg_cache_dma_to_wormhole_initiator_counter
  #(parameter int max_val_p = 7
   ,parameter int width_p   = (max_val_p > 0) ? $clog2(max_val_p+1) : 1)
  (input  logic               clk_i
  ,input  logic               reset_n_i
  ,input  logic               clear_i
  ,input  logic               up_i
  ,input  logic               down_i
  ,output logic [width_p-1:0] count_o
  );

  // Simultaneous up and down cancel out.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      count_o <= '0;
    else if (clear_i)
      count_o <= '0;
    else if (up_i & ~down_i)
      count_o <= count_o + width_p'(1);
    else if (down_i & ~up_i)
      count_o <= count_o - width_p'(1);
  end

endmodule

// File: rtl/bsg_cache_dma_to_wormhole_initiator.sv
// Initiator side of the cache wormhole memory protocol: serializes vcache DMA
// requests and evict data into wormhole packets and returns fill data.
module bsg_cache_dma_to_wormhole_initiator
  import bsg_cache_dma_to_wormhole_initiator_pkg::*;
  #(parameter int dma_addr_width_p      = 32
   ,parameter int data_width_p          = 32
   ,parameter int block_size_in_words_p = 8
   ,parameter int dma_data_width_p      = 32
   ,parameter int wh_flit_width_p       = 32
   ,parameter int wh_cid_width_p        = 2
   ,parameter int wh_cord_width_p       = 8
   ,parameter int wh_len_width_p        = 4
   ,parameter int max_out_reads_p       = 4
   ,localparam int data_len_lp      = block_size_in_words_p/(dma_data_width_p/data_width_p)
   ,localparam int dma_pkt_width_lp = 1+dma_addr_width_p+block_size_in_words_p
   ,localparam int link_width_lp    = wh_flit_width_p+2)
  (input  logic                        clk_i
  ,input  logic                        reset_n_i
  ,input  logic [wh_cord_width_p-1:0]  my_cord_i
  ,input  logic [wh_cid_width_p-1:0]   my_cid_i
  ,input  logic [wh_cord_width_p-1:0]  dest_cord_i
  ,input  logic [wh_cid_width_p-1:0]   dest_cid_i
  ,input  logic [dma_pkt_width_lp-1:0] dma_pkt_i
  ,input  logic                        dma_pkt_v_i
  ,output logic                        dma_pkt_yumi_o
  ,output logic [dma_data_width_p-1:0] dma_data_o
  ,output logic                        dma_data_v_o
  ,input  logic                        dma_data_ready_and_i
  ,input  logic [dma_data_width_p-1:0] dma_data_i
  ,input  logic                        dma_data_v_i
  ,output logic                        dma_data_yumi_o
  ,input  logic [link_width_lp-1:0]    wh_link_sif_i
  ,output logic [link_width_lp-1:0]    wh_link_sif_o
  );

  typedef enum logic [2:0] {TX_IDLE, TX_HEADER, TX_ADDR, TX_MASK, TX_DATA} tx_state_e;
  typedef enum logic {RX_HEADER, RX_DATA} rx_state_e;

  localparam int cnt_width_lp  = (data_len_lp > 1) ? $clog2(data_len_lp) : 1;
  localparam int pend_width_lp = $clog2(max_out_reads_p+1);
  localparam logic [cnt_width_lp-1:0]  last_beat_lp = cnt_width_lp'(data_len_lp-1);
  localparam logic [pend_width_lp-1:0] max_reads_lp = pend_width_lp'(max_out_reads_p);

  tx_state_e tx_state_r, tx_state_n;
  rx_state_e rx_state_r, rx_state_n;

  logic                             pkt_wnr;
  logic [dma_addr_width_p-1:0]      pkt_addr;
  logic [block_size_in_words_p-1:0] pkt_mask;
  assign {pkt_wnr, pkt_addr, pkt_mask} = dma_pkt_i;

  bsg_cache_wh_opcode_e             opcode_r;
  logic [dma_addr_width_p-1:0]      addr_r;
  logic [block_size_in_words_p-1:0] mask_r;

  logic                       in_v, in_ready;
  logic [wh_flit_width_p-1:0] in_data;
  assign {in_v, in_data, in_ready} = wh_link_sif_i;

  logic                       out_v, out_ready;
  logic [wh_flit_width_p-1:0] out_data, header_flit;
  logic [wh_len_width_p-1:0]  len;

  logic pkt_yumi, evict_yumi, fill_v;
  logic read_inc, read_dec;
  logic tx_cnt_up, tx_cnt_clr, rx_cnt_up, rx_cnt_clr;
  logic [cnt_width_lp-1:0]  tx_cnt, rx_cnt;
  logic [pend_width_lp-1:0] reads_pending;

  // Header len counts the flits that follow the header.
  always_comb begin
    case (opcode_r)
      e_cache_wh_write_non_masked: len = wh_len_width_p'(1+data_len_lp);
      e_cache_wh_write_masked:     len = wh_len_width_p'(2+data_len_lp);
      default:                     len = wh_len_width_p'(1);
    endcase
  end

  assign header_flit = wh_flit_width_p'({opcode_r, my_cid_i, my_cord_i, dest_cid_i, len, dest_cord_i});

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state_r <= TX_IDLE;
      rx_state_r <= RX_HEADER;
      opcode_r   <= e_cache_wh_read;
      addr_r     <= '0;
      mask_r     <= '0;
    end
    else begin
      tx_state_r <= tx_state_n;
      rx_state_r <= rx_state_n;
      if (pkt_yumi) begin
        opcode_r <= wh_opcode_sel(pkt_wnr, &pkt_mask);
        addr_r   <= pkt_addr;
        mask_r   <= pkt_mask;
      end
    end
  end

  always_comb begin
    tx_state_n = tx_state_r;
    out_v      = 1'b0;
    out_data   = '0;
    pkt_yumi   = 1'b0;
    evict_yumi = 1'b0;
    read_inc   = 1'b0;
    tx_cnt_up  = 1'b0;
    tx_cnt_clr = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        pkt_yumi = dma_pkt_v_i & (pkt_wnr | (reads_pending < max_reads_lp));
        if (pkt_yumi) tx_state_n = TX_HEADER;
      end
      TX_HEADER: begin
        out_v    = 1'b1;
        out_data = header_flit;
        if (in_ready) tx_state_n = TX_ADDR;
      end
      TX_ADDR: begin
        out_v    = 1'b1;
        out_data = wh_flit_width_p'(addr_r);
        if (in_ready) begin
          case (opcode_r)
            e_cache_wh_read: begin
              read_inc   = 1'b1;
              tx_state_n = TX_IDLE;
            end
            e_cache_wh_write_non_masked: tx_state_n = TX_DATA;
            default:                     tx_state_n = TX_MASK;
          endcase
        end
      end
      TX_MASK: begin
        out_v    = 1'b1;
        out_data = wh_flit_width_p'(mask_r);
        if (in_ready) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        out_v      = dma_data_v_i;
        out_data   = dma_data_i;
        evict_yumi = dma_data_v_i & in_ready;
        tx_cnt_up  = evict_yumi;
        if (evict_yumi && (tx_cnt == last_beat_lp)) begin
          tx_cnt_clr = 1'b1;
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // The response header len is not inspected; a fill is always one full block.
  always_comb begin
    rx_state_n = rx_state_r;
    out_ready  = 1'b0;
    fill_v     = 1'b0;
    read_dec   = 1'b0;
    rx_cnt_up  = 1'b0;
    rx_cnt_clr = 1'b0;
    case (rx_state_r)
      RX_HEADER: begin
        out_ready = 1'b1;
        if (in_v) rx_state_n = RX_DATA;
      end
      RX_DATA: begin
        fill_v    = in_v;
        out_ready = dma_data_ready_and_i;
        rx_cnt_up = in_v & dma_data_ready_and_i;
        if (rx_cnt_up && (rx_cnt == last_beat_lp)) begin
          rx_cnt_clr = 1'b1;
          read_dec   = 1'b1;
          rx_state_n = RX_HEADER;
        end
      end
      default: rx_state_n = RX_HEADER;
    endcase
  end

  bsg_cache_dma_to_wormhole_initiator_counter
    #(.max_val_p(data_len_lp-1), .width_p(cnt_width_lp))
    tx_count
      (.clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(tx_cnt_clr)
      ,.up_i(tx_cnt_up), .down_i(1'b0), .count_o(tx_cnt));

  bsg_cache_dma_to_wormhole_initiator_counter
    #(.max_val_p(data_len_lp-1), .width_p(cnt_width_lp))
    rx_count
      (.clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(rx_cnt_clr)
      ,.up_i(rx_cnt_up), .down_i(1'b0), .count_o(rx_cnt));

  bsg_cache_dma_to_wormhole_initiator_counter
    #(.max_val_p(max_out_reads_p), .width_p(pend_width_lp))
    pending_count
      (.clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(1'b0)
      ,.up_i(read_inc), .down_i(read_dec), .count_o(reads_pending));

  // Control outputs are forced low for as long as reset is held.
  assign dma_pkt_yumi_o  = pkt_yumi & reset_n_i;
  assign dma_data_yumi_o = evict_yumi & reset_n_i;
  assign dma_data_v_o    = fill_v & reset_n_i;
  assign dma_data_o      = in_data;
  assign wh_link_sif_o   = {out_v & reset_n_i, out_data, out_ready & reset_n_i};

endmodule

// File: tb/tb_bsg_cache_dma_to_wormhole_initiator.sv
// Directed self-checking bench for the cache DMA to wormhole initiator.
module tb_bsg_cache_dma_to_wormhole_initiator;

  localparam int pkt_w  = 1+32+8;
  localparam int link_w = 32+2;

  // Header flits hand-computed for my_cord=0x12, my_cid=1, dest_cord=0x34, dest_cid=2
  localparam logic [31:0] hdr_read_c   = 32'h0044_A134;
  localparam logic [31:0] hdr_nm_c     = 32'h0144_A934;
  localparam logic [31:0] hdr_masked_c = 32'h0244_AA34;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [7:0]        my_cord_i   = 8'h12;
  logic [1:0]        my_cid_i    = 2'd1;
  logic [7:0]        dest_cord_i = 8'h34;
  logic [1:0]        dest_cid_i  = 2'd2;
  logic [pkt_w-1:0]  dma_pkt_i;
  logic              dma_pkt_v_i;
  logic              dma_pkt_yumi_o;
  logic [31:0]       dma_data_o;
  logic              dma_data_v_o;
  logic              dma_data_ready_and_i;
  logic [31:0]       dma_data_i;
  logic              dma_data_v_i;
  logic              dma_data_yumi_o;
  logic [link_w-1:0] wh_link_sif_i;
  logic [link_w-1:0] wh_link_sif_o;

  bsg_cache_dma_to_wormhole_initiator dut
    (.clk_i(clk_i), .reset_n_i(reset_n_i)
    ,.my_cord_i(my_cord_i), .my_cid_i(my_cid_i)
    ,.dest_cord_i(dest_cord_i), .dest_cid_i(dest_cid_i)
    ,.dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o)
    ,.dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o)
    ,.dma_data_ready_and_i(dma_data_ready_and_i)
    ,.dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o)
    ,.wh_link_sif_i(wh_link_sif_i), .wh_link_sif_o(wh_link_sif_o));

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gap = 0;
  int pkt_fire_cnt = 0;
  int last_pkt_fire_cyc = 0;
  int last_fill_cyc = 0;

  logic [pkt_w-1:0] pkt_q[$];
  logic [31:0]      evict_q[$];
  logic [31:0]      rsp_q[$];
  logic [31:0]      tx_q[$];
  logic [31:0]      fill_q[$];

  bit          rand_mode = 1'b0;
  bit          tx_ready = 1'b1;
  bit          fill_ready = 1'b1;
  bit          pkt_fire, evict_fire, rsp_fire, prev_stall;
  logic [31:0] prev_data;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    dma_pkt_v_i          = (pkt_q.size() > 0);
    dma_pkt_i            = (pkt_q.size() > 0) ? pkt_q[0] : '0;
    dma_data_v_i         = (evict_q.size() > 0) && (gap == 0);
    dma_data_i           = (evict_q.size() > 0) ? evict_q[0] : 32'h0;
    wh_link_sif_i        = {(rsp_q.size() > 0), ((rsp_q.size() > 0) ? rsp_q[0] : 32'h0), tx_ready};
    dma_data_ready_and_i = fill_ready;
  endtask

  // One clock: drive, sample at the falling edge, then advance the sources.
  task automatic cycle();
    logic        out_v;
    logic [31:0] out_data;
    applyStimulus();
    @(negedge clk_i);
    pkt_fire   = 1'b0;
    evict_fire = 1'b0;
    rsp_fire   = 1'b0;
    if (reset_n_i) begin
      out_v    = wh_link_sif_o[33];
      out_data = wh_link_sif_o[32:1];
      if (prev_stall) begin
        checkOutput("hold_v", out_v, 1);
        checkOutput("hold_flit", out_data, prev_data);
      end
      prev_stall = out_v && !tx_ready;
      prev_data  = out_data;
      if (out_v && tx_ready) tx_q.push_back(out_data);
      if (dma_data_v_o && fill_ready) begin
        fill_q.push_back(dma_data_o);
        last_fill_cyc = cyc;
      end
      rsp_fire   = wh_link_sif_i[33] && wh_link_sif_o[0];
      pkt_fire   = dma_pkt_yumi_o;
      evict_fire = dma_data_yumi_o;
      if (pkt_fire) begin
        pkt_fire_cnt++;
        last_pkt_fire_cyc = cyc;
      end
    end
    else prev_stall = 1'b0;
    @(posedge clk_i);
    #1;
    cyc++;
    if (pkt_fire) void'(pkt_q.pop_front());
    if (evict_fire) begin
      void'(evict_q.pop_front());
      gap = rand_mode ? int'($urandom_range(0, 2)) : 0;
    end
    else if (gap > 0) gap--;
    if (rsp_fire) void'(rsp_q.pop_front());
    tx_ready   = rand_mode ? bit'($urandom_range(0, 1)) : 1'b1;
    fill_ready = rand_mode ? bit'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    checkOutput(tag, (tx_q.size() >= n), 1);
  endtask

  task automatic wait_fill(input int n, input int budget, input string tag);
    int k = 0;
    while (fill_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    checkOutput(tag, (fill_q.size() >= n), 1);
  endtask

  task automatic push_response(input logic [31:0] base);
    rsp_q.push_back(32'hC0DE_0000 | base);
    for (int b = 0; b < 8; b++) rsp_q.push_back(base + b);
  endtask

  initial begin
    int start_cnt;
    int k;

    // Reset holds every control output low even with a packet waiting
    reset_n_i = 1'b0;
    pkt_q.push_back({1'b0, 32'h0000_1040, 8'h00});
    applyStimulus();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_pkt_yumi", dma_pkt_yumi_o, 0);
    checkOutput("rst_link_v", wh_link_sif_o[33], 0);
    checkOutput("rst_link_ready", wh_link_sif_o[0], 0);
    checkOutput("rst_fill_v", dma_data_v_o, 0);
    checkOutput("rst_evict_yumi", dma_data_yumi_o, 0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;

    // Read 0x1040 and its 8-beat fill
    wait_tx(2, 20, "rd_tx_timeout");
    checkOutput("rd_header", tx_q[0], hdr_read_c);
    checkOutput("rd_addr", tx_q[1], 32'h0000_1040);
    push_response(32'h0);
    wait_fill(8, 40, "rd_fill_timeout");
    for (int i = 0; i < 8; i++) checkOutput("rd_fill_beat", fill_q[i], i);
    tx_q.delete();
    fill_q.delete();

    // Full-mask write: no mask flit
    pkt_q.push_back({1'b1, 32'h0000_2000, 8'hFF});
    for (int i = 0; i < 8; i++) evict_q.push_back(32'hA0 + i);
    wait_tx(10, 40, "wr_tx_timeout");
    repeat (5) cycle();
    checkOutput("wr_flit_count", tx_q.size(), 10);
    checkOutput("wr_header", tx_q[0], hdr_nm_c);
    checkOutput("wr_addr", tx_q[1], 32'h0000_2000);
    for (int i = 0; i < 8; i++) checkOutput("wr_data", tx_q[2+i], 32'hA0 + i);
    tx_q.delete();

    // Masked write under random backpressure and evict gaps
    rand_mode = 1'b1;
    pkt_q.push_back({1'b1, 32'h0000_3000, 8'h0F});
    for (int i = 0; i < 8; i++) evict_q.push_back(32'hB0 + i);
    wait_tx(11, 300, "mw_tx_timeout");
    rand_mode = 1'b0;
    repeat (5) cycle();
    checkOutput("mw_flit_count", tx_q.size(), 11);
    checkOutput("mw_header", tx_q[0], hdr_masked_c);
    checkOutput("mw_addr", tx_q[1], 32'h0000_3000);
    checkOutput("mw_mask", tx_q[2], 32'h0000_000F);
    for (int i = 0; i < 8; i++) checkOutput("mw_data", tx_q[3+i], 32'hB0 + i);
    tx_q.delete();

    // Five reads against a limit of four outstanding
    start_cnt = pkt_fire_cnt;
    for (int r = 0; r < 5; r++) pkt_q.push_back({1'b0, 32'h100 * (r+1), 8'h00});
    repeat (60) cycle();
    checkOutput("lim_accepted", pkt_fire_cnt - start_cnt, 4);
    checkOutput("lim_flits", tx_q.size(), 8);
    checkOutput("lim_addr4", tx_q[7], 32'h400);
    push_response(32'h10);
    k = 0;
    while (pkt_fire_cnt - start_cnt < 5 && k < 60) begin
      cycle();
      k++;
    end
    checkOutput("lim_fifth_yumi", pkt_fire_cnt - start_cnt, 5);
    checkOutput("lim_fifth_fills", fill_q.size(), 8);
    checkOutput("lim_fifth_cycle", last_pkt_fire_cyc, last_fill_cyc + 1);
    for (int r = 1; r < 5; r++) push_response(32'h10 * (r+1));
    wait_fill(40, 200, "lim_fill_timeout");
    wait_tx(10, 20, "lim_tx_timeout");
    checkOutput("lim_addr5", tx_q[9], 32'h500);
    for (int i = 0; i < 40; i++) checkOutput("lim_fill_order", fill_q[i], 32'h10 * (i/8 + 1) + (i%8));
    tx_q.delete();
    fill_q.delete();

    // Asynchronous reset in the middle of write data
    pkt_q.push_back({1'b1, 32'h0000_4000, 8'hFF});
    for (int i = 0; i < 8; i++) evict_q.push_back(32'hC0 + i);
    wait_tx(5, 30, "ar_tx_timeout");
    applyStimulus();
    #2;
    checkOutput("ar_pre_link_v", wh_link_sif_o[33], 1);
    checkOutput("ar_pre_evict_yumi", dma_data_yumi_o, 1);
    reset_n_i = 1'b0;
    #1;
    checkOutput("ar_link_v", wh_link_sif_o[33], 0);
    checkOutput("ar_evict_yumi", dma_data_yumi_o, 0);
    checkOutput("ar_link_ready", wh_link_sif_o[0], 0);
    checkOutput("ar_fill_v", dma_data_v_o, 0);
    pkt_q.delete();
    evict_q.delete();
    rsp_q.delete();
    gap = 0;
    repeat (2) cycle();
    reset_n_i = 1'b1;
    tx_q.delete();
    fill_q.delete();

    // Fresh read after reset, with random backpressure on both sides
    rand_mode = 1'b1;
    pkt_q.push_back({1'b0, 32'h0000_5000, 8'h00});
    wait_tx(2, 60, "pr_tx_timeout");
    checkOutput("pr_header", tx_q[0], hdr_read_c);
    checkOutput("pr_addr", tx_q[1], 32'h0000_5000);
    push_response(32'h50);
    wait_fill(8, 200, "pr_fill_timeout");
    for (int i = 0; i < 8; i++) checkOutput("pr_fill_beat", fill_q[i], 32'h50 + i);
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
